// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: octant code layout, octant type and the shift-width helper.
package cordic_pkg;

  localparam int Q_SWAP = 0;
  localparam int Q_XNEG = 1;
  localparam int Q_YNEG = 2;

  typedef logic [2:0] octant_t;

  // Width of a left-shift count able to address every bit position of a w-bit word.
  function automatic int shift_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cordic_lzc.sv
// Combinational leading-zero count; an all-zero input reports 0.
module cordic_lzc
  import cordic_pkg::*;
#(
  parameter int W = 16,
  localparam int SW = shift_w(W)
) (
  input  logic [W-1:0]  d,
  output logic [SW-1:0] cnt
);

  logic found;

  always_comb begin
    cnt   = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (d[i]) found = 1'b1;
        else      cnt   = cnt + SW'(1);
      end
    end
    if (!found) cnt = '0;
  end

endmodule

// File: rtl/cordic_pre_octant.sv
// CORDIC pre-stage: abs, fold into first octant, optional normalise (CORDIC_PRE_NORM_EN).
// Valid/ready: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module cordic_pre_octant
  import cordic_pkg::*;
#(
  parameter int W     = 16,
  parameter int TAG_W = 4,
  localparam int SW   = shift_w(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     xi,
  input  logic [W-1:0]     yi,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     xo,
  output logic [W-1:0]     yo,
  output octant_t          q,
  output logic [TAG_W-1:0] tag_o,
  output logic [SW-1:0]    shift_o
);

  logic             v1_q, v1_d, xneg1_q, xneg1_d, yneg1_q, yneg1_d;
  logic [W-1:0]     ax1_q, ax1_d, ay1_q, ay1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;
  logic             v2_q, v2_d;
  logic [W-1:0]     x2_q, x2_d, y2_q, y2_d;
  octant_t          q2_q, q2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;
  logic             ld1, ld2, ds_ready2;

  // A stage loads when empty or when its contents leave in the same cycle.
  assign ld2      = !v2_q || ds_ready2;
  assign ld1      = !v1_q || ld2;
  assign in_ready = ld1;

  always_comb begin
    v1_d    = flush ? 1'b0 : (ld1 ? in_valid : v1_q);
    ax1_d   = ax1_q;
    ay1_d   = ay1_q;
    xneg1_d = xneg1_q;
    yneg1_d = yneg1_q;
    tag1_d  = tag1_q;
    if (in_valid && ld1) begin
      ax1_d   = xi[W-1] ? (~xi + 1'b1) : xi;
      ay1_d   = yi[W-1] ? (~yi + 1'b1) : yi;
      xneg1_d = xi[W-1];
      yneg1_d = yi[W-1];
      tag1_d  = tag_i;
    end
  end

  // Strict compare: equal magnitudes stay unswapped.
  always_comb begin
    v2_d   = flush ? 1'b0 : (ld2 ? v1_q : v2_q);
    x2_d   = x2_q;
    y2_d   = y2_q;
    q2_d   = q2_q;
    tag2_d = tag2_q;
    if (v1_q && ld2) begin
      q2_d         = '0;
      q2_d[Q_SWAP] = ay1_q > ax1_q;
      q2_d[Q_XNEG] = xneg1_q;
      q2_d[Q_YNEG] = yneg1_q;
      x2_d         = (ay1_q > ax1_q) ? ay1_q : ax1_q;
      y2_d         = (ay1_q > ax1_q) ? ax1_q : ay1_q;
      tag2_d       = tag1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      ax1_q   <= '0;
      ay1_q   <= '0;
      xneg1_q <= 1'b0;
      yneg1_q <= 1'b0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      x2_q    <= '0;
      y2_q    <= '0;
      q2_q    <= '0;
      tag2_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      ax1_q   <= ax1_d;
      ay1_q   <= ay1_d;
      xneg1_q <= xneg1_d;
      yneg1_q <= yneg1_d;
      tag1_q  <= tag1_d;
      v2_q    <= v2_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      q2_q    <= q2_d;
      tag2_q  <= tag2_d;
    end
  end

`ifdef CORDIC_PRE_NORM_EN
  logic             v3_q, v3_d, ld3;
  logic [W-1:0]     x3_q, x3_d, y3_q, y3_d;
  octant_t          q3_q, q3_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;
  logic [SW-1:0]    sh3_q, sh3_d, lz;

  cordic_lzc #(.W(W)) u_lzc (.d(x2_q), .cnt(lz));

  assign ld3       = !v3_q || out_ready;
  assign ds_ready2 = ld3;

  always_comb begin
    v3_d   = flush ? 1'b0 : (ld3 ? v2_q : v3_q);
    x3_d   = x3_q;
    y3_d   = y3_q;
    q3_d   = q3_q;
    tag3_d = tag3_q;
    sh3_d  = sh3_q;
    if (v2_q && ld3) begin
      x3_d   = x2_q << lz;
      y3_d   = y2_q << lz;
      q3_d   = q2_q;
      tag3_d = tag2_q;
      sh3_d  = lz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q   <= 1'b0;
      x3_q   <= '0;
      y3_q   <= '0;
      q3_q   <= '0;
      tag3_q <= '0;
      sh3_q  <= '0;
    end else begin
      v3_q   <= v3_d;
      x3_q   <= x3_d;
      y3_q   <= y3_d;
      q3_q   <= q3_d;
      tag3_q <= tag3_d;
      sh3_q  <= sh3_d;
    end
  end

  assign out_valid = v3_q;
  assign xo        = x3_q;
  assign yo        = y3_q;
  assign q         = q3_q;
  assign tag_o     = tag3_q;
  assign shift_o   = sh3_q;
`else
  assign ds_ready2 = out_ready;
  assign out_valid = v2_q;
  assign xo        = x2_q;
  assign yo        = y2_q;
  assign q         = q2_q;
  assign tag_o     = tag2_q;
  assign shift_o   = '0;
`endif

endmodule
